// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: consumes DIGIT bits per clock, LSB digit first,
// built from a ripple chain of full-adder cells with valid/ready handshakes on both sides.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  // Handshake rule: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its payload stable until that edge.

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   dcarry;
  logic             accept;
  logic             last;

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (state == RUN) && (cnt == CNT_W'(N - 1));

  // One digit worth of full-adder cells, rippling the carry held between cycles.
  assign dcarry[0] = carry;
  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      full_adder u_fa (
        .a  (a_sh[i]),
        .b  (b_sh[i]),
        .ci (dcarry[i]),
        .s  (dsum[i]),
        .co (dcarry[i+1])
      );
    end
  endgenerate

  // New digit enters at the MSB end so after N shifts the LSB digit sits at bit 0.
  generate
    if (N == 1) begin : g_acc_single
      assign acc_next = dsum;
    end else begin : g_acc_shift
      assign acc_next = {dsum, acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          acc   <= acc_next;
          carry <= dcarry[DIGIT];
          cnt   <= cnt + 1'b1;
          // Outputs only change on the final digit, so they hold through IDLE and RUN.
          if (last) begin
            sum  <= acc_next;
            cout <= dcarry[DIGIT];
            ovf  <= (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench: directed scenarios on an 8-bit/1-bit-digit unit and a
// randomised scoreboard run on a 16-bit/4-bit-digit unit.

module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit, 1-bit digit instance
  logic       d8_in_valid = 1'b0;
  logic       d8_in_ready;
  logic [7:0] d8_a = '0;
  logic [7:0] d8_b = '0;
  logic       d8_cin = 1'b0;
  logic       d8_sub = 1'b0;
  logic       d8_out_valid;
  logic       d8_out_ready = 1'b0;
  logic [7:0] d8_sum;
  logic       d8_cout;
  logic       d8_ovf;

  // 16-bit, 4-bit digit instance
  logic        d16_in_valid = 1'b0;
  logic        d16_in_ready;
  logic [15:0] d16_a = '0;
  logic [15:0] d16_b = '0;
  logic        d16_cin = 1'b0;
  logic        d16_sub = 1'b0;
  logic        d16_out_valid;
  logic        d16_out_ready = 1'b0;
  logic [15:0] d16_sum;
  logic        d16_cout;
  logic        d16_ovf;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .a(d8_a), .b(d8_b), .cin(d8_cin), .sub(d8_sub),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .sum(d8_sum), .cout(d8_cout), .ovf(d8_ovf)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(d16_in_valid), .in_ready(d16_in_ready),
    .a(d16_a), .b(d16_b), .cin(d16_cin), .sub(d16_sub),
    .out_valid(d16_out_valid), .out_ready(d16_out_ready),
    .sum(d16_sum), .cout(d16_cout), .ovf(d16_ovf)
  );

  // Drives one 8-bit operation through accept, result and handshake; reports what it saw.
  task automatic drive_op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                           input logic sb, output logic [7:0] s, output logic co,
                           output logic ov, output int lat, output bit to);
    int w;
    to = 1'b0; lat = 0; w = 0;
    s = '0; co = 1'b0; ov = 1'b0;
    d8_a = av; d8_b = bv; d8_cin = ci; d8_sub = sb; d8_in_valid = 1'b1;
    while (!d8_in_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!d8_in_ready) begin to = 1'b1; d8_in_valid = 1'b0; return; end
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    while (!d8_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!d8_out_valid) begin to = 1'b1; return; end
    s = d8_sum; co = d8_cout; ov = d8_ovf;
    d8_out_ready = 1'b1;
    @(posedge clk); #1;
    d8_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (d8_in_ready !== 1'b0) begin $display("FAIL reset_in_ready got %b want 0", d8_in_ready); n_fail++; end
    n_cmp++; if (d8_out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", d8_out_valid); n_fail++; end
    n_cmp++; if ({d8_sum, d8_cout, d8_ovf} !== 10'h000) begin
      $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b want 00/0/0", d8_sum, d8_cout, d8_ovf); n_fail++; end
    rst = 1'b0;
    #1;
    n_cmp++; if (d8_in_ready !== 1'b1) begin $display("FAIL reset_release_in_ready got %b want 1", d8_in_ready); n_fail++; end
  endtask

  task automatic test_vector(input string name, input logic [7:0] av, input logic [7:0] bv,
                             input logic ci, input logic sb, input logic [7:0] es,
                             input logic ec, input logic eo);
    logic [7:0] s; logic co, ov; int lat; bit to;
    drive_op8(av, bv, ci, sb, s, co, ov, lat, to);
    n_cmp++; if (to) begin $display("FAIL %s timeout waiting for handshake", name); n_fail++; end
    n_cmp++; if (s !== es) begin $display("FAIL %s sum got %h want %h", name, s, es); n_fail++; end
    n_cmp++; if (co !== ec) begin $display("FAIL %s cout got %b want %b", name, co, ec); n_fail++; end
    n_cmp++; if (ov !== eo) begin $display("FAIL %s ovf got %b want %b", name, ov, eo); n_fail++; end
    n_cmp++; if (lat !== 8) begin $display("FAIL %s latency got %0d want 8", name, lat); n_fail++; end
    n_cmp++; if (d8_in_ready !== 1'b1 || d8_sum !== es) begin
      $display("FAIL %s idle_hold got ready=%b sum=%h want 1/%h", name, d8_in_ready, d8_sum, es); n_fail++; end
  endtask

  task automatic test_backpressure();
    int lat;
    d8_a = 8'h12; d8_b = 8'h34; d8_cin = 1'b0; d8_sub = 1'b0; d8_in_valid = 1'b1;
    @(posedge clk); #1;
    d8_a = 8'h01; d8_b = 8'h01;
    lat = 0;
    while (!d8_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 8) begin $display("FAIL bp_latency got %0d want 8", lat); n_fail++; end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({d8_out_valid, d8_in_ready, d8_sum, d8_cout, d8_ovf} !== {1'b1, 1'b0, 8'h46, 1'b0, 1'b0}) begin
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b sum=%h cout=%b ovf=%b want 1/0/46/0/0",
                 i, d8_out_valid, d8_in_ready, d8_sum, d8_cout, d8_ovf); n_fail++; end
      @(posedge clk); #1;
    end
    d8_out_ready = 1'b1;
    @(posedge clk); #1;
    d8_out_ready = 1'b0;
    n_cmp++; if (d8_in_ready !== 1'b1 || d8_out_valid !== 1'b0) begin
      $display("FAIL bp_after_handshake got ready=%b valid=%b want 1/0", d8_in_ready, d8_out_valid); n_fail++; end
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    n_cmp++; if (d8_in_ready !== 1'b0) begin $display("FAIL bp_next_accept got ready=%b want 0", d8_in_ready); n_fail++; end
    lat = 0;
    while (!d8_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 8 || d8_sum !== 8'h02 || d8_cout !== 1'b0) begin
      $display("FAIL bp_next_op got lat=%0d sum=%h cout=%b want 8/02/0", lat, d8_sum, d8_cout); n_fail++; end
    d8_out_ready = 1'b1;
    @(posedge clk); #1;
    d8_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit seen_valid;
    d8_a = 8'hA5; d8_b = 8'h5A; d8_cin = 1'b1; d8_sub = 1'b0; d8_in_valid = 1'b1;
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_cmp++; if (d8_in_ready !== 1'b0) begin $display("FAIL abort_in_ready_in_rst got %b want 0", d8_in_ready); n_fail++; end
    @(posedge clk); #1;
    n_cmp++; if ({d8_out_valid, d8_sum, d8_cout, d8_ovf} !== 11'h000) begin
      $display("FAIL abort_cleared got valid=%b sum=%h cout=%b ovf=%b want 0/00/0/0", d8_out_valid, d8_sum, d8_cout, d8_ovf); n_fail++; end
    rst = 1'b0;
    #1;
    n_cmp++; if (d8_in_ready !== 1'b1) begin $display("FAIL abort_release_in_ready got %b want 1", d8_in_ready); n_fail++; end
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (d8_out_valid) seen_valid = 1'b1; end
    n_cmp++; if (seen_valid) begin $display("FAIL abort_no_result got out_valid=1 want 0"); n_fail++; end
  endtask

  task automatic test_random16();
    logic [15:0] av, bv, bb, s_obs;
    logic ci, sb, c_obs, o_obs;
    logic [16:0] t;
    logic [17:0] exp_v;
    int w, lat, stall;
    for (int i = 0; i < 1000; i++) begin
      av = 16'($urandom); bv = 16'($urandom);
      ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      bb = sb ? ~bv : bv;
      t = {1'b0, av} + {1'b0, bb} + {16'h0, (sb ? 1'b1 : ci)};
      exp_v = {t[16], (av[15] == bb[15]) && (t[15] != av[15]), t[15:0]};
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d16_a = av; d16_b = bv; d16_cin = ci; d16_sub = sb; d16_in_valid = 1'b1;
      w = 0;
      while (!d16_in_ready && w < 50) begin @(posedge clk); #1; w++; end
      if (!d16_in_ready) begin $display("FAIL rand_accept op %0d timeout", i); n_cmp++; n_fail++; break; end
      exp_q.push_back(exp_v);
      @(posedge clk); #1;
      lat = 0;
      while (!d16_out_valid && lat < 50) begin
        d16_in_valid = 1'($urandom_range(0, 1));
        d16_a = 16'($urandom); d16_b = 16'($urandom);
        @(posedge clk); #1; lat++;
      end
      d16_in_valid = 1'b0;
      if (!d16_out_valid) begin $display("FAIL rand_result op %0d timeout", i); n_cmp++; n_fail++; break; end
      n_cmp++; if (lat !== 4) begin $display("FAIL rand_latency op %0d got %0d want 4", i, lat); n_fail++; end
      s_obs = d16_sum; c_obs = d16_cout; o_obs = d16_ovf;
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        if ({d16_out_valid, d16_sum, d16_cout, d16_ovf} !== {1'b1, s_obs, c_obs, o_obs}) begin
          n_cmp++; n_fail++;
          $display("FAIL rand_hold op %0d got valid=%b sum=%h want 1/%h", i, d16_out_valid, d16_sum, s_obs);
        end
      end
      d16_out_ready = 1'b1;
      @(posedge clk); #1;
      d16_out_ready = 1'b0;
      exp_v = exp_q.pop_front();
      n_cmp++; if ({c_obs, o_obs, s_obs} !== exp_v) begin
        $display("FAIL rand_result op %0d a=%h b=%h cin=%b sub=%b got cout=%b ovf=%b sum=%h want cout=%b ovf=%b sum=%h",
                 i, av, bv, ci, sb, c_obs, o_obs, s_obs, exp_v[17], exp_v[16], exp_v[15:0]); n_fail++; end
    end
  endtask

  initial begin
    test_reset();
    test_vector("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    test_vector("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    test_vector("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    test_vector("add_cin",  8'h05, 8'h03, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0);
    test_vector("sub_borrow", 8'h3C, 8'h5A, 1'b1, 1'b1, 8'hE2, 1'b0, 1'b0);
    test_backpressure();
    test_reset_mid_run();
    test_vector("after_abort", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
